// File: rtl/ssd_scan_controller.sv
// Scan sequencer for a multiplexed 4-digit seven-segment display.
// Buffers received bytes as nibbles and time-multiplexes digit selects.
module ssd_scan_controller #(
    parameter int PAYLOAD_BITS   = 8,
    parameter int SCAN_DIV       = 208_333,
    parameter int BLANK_CYCLES   = 500,
    parameter int TIMEOUT_FRAMES = 120
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PAYLOAD_BITS-1:0] rx_data,
    input  logic                    rx_valid,
    input  logic                    clear,
    output logic [3:0]              input_bits,
    output logic                    dash,
    output logic [3:0]              dig_sel,
    output logic                    frame_tick
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_TICK  = CW'(SCAN_DIV - 2);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES - 1);
    localparam logic [FW-1:0] FR_LAST   =
        FW'((TIMEOUT_FRAMES > 0) ? TIMEOUT_FRAMES - 1 : 0);
    localparam logic [FW-1:0] FR_MAX    = FW'(TIMEOUT_FRAMES);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [15:0]   buf_q, buf_d;
    logic [3:0]    valid_q, valid_d;
    logic [3:0]    dig_q, dig_d;
    logic [3:0]    bits_q, bits_d;
    logic          dash_q, dash_d;
    logic          tick_q, tick_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BLANK;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            frame_q <= '0;
            buf_q   <= 16'h0000;
            valid_q <= 4'b0000;
            dig_q   <= 4'b0000;
            bits_q  <= 4'h0;
            dash_q  <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            buf_q   <= buf_d;
            valid_q <= valid_d;
            dig_q   <= dig_d;
            bits_q  <= bits_d;
            dash_q  <= dash_d;
            tick_q  <= tick_d;
        end
    end

    // Scan sequencer: the pulse is predicted one cycle early so it
    // lands registered on the final cycle of digit 3's slot.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + 1'b1;
        dig_d   = dig_q;
        bits_d  = bits_q;
        dash_d  = dash_q;
        tick_d  = (idx_q == 2'd3) && (cnt_q == CNT_TICK);
        unique case (state_q)
            BLANK: begin
                if (cnt_q == CNT_BLANK) begin
                    state_d = SHOW;
                    dig_d   = 4'b0001 << idx_q;
                end
            end
            SHOW: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    dig_d   = 4'b0000;
                    bits_d  = buf_q[{idx_d, 2'b00} +: 4];
                    dash_d  = ~valid_q[idx_d];
                end
            end
        endcase
    end

    // Buffer, valid flags and timeout; later assignments take priority.
    always_comb begin
        buf_d   = buf_q;
        valid_d = valid_q;
        frame_d = frame_q;
        if ((TIMEOUT_FRAMES != 0) && tick_q && (frame_q != FR_MAX)) begin
            if (frame_q == FR_LAST) begin
                valid_d = 4'b0000;
                frame_d = FR_MAX;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
        if (rx_valid) begin
            buf_d   = {buf_q[7:0], rx_data[7:0]};
            valid_d = {valid_q[1:0], 2'b11};
            frame_d = '0;
        end
        if (clear) begin
            buf_d   = buf_q;
            valid_d = 4'b0000;
            frame_d = '0;
        end
    end

    assign input_bits = bits_q;
    assign dash       = dash_q;
    assign dig_sel    = dig_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Scoreboard bench for ssd_scan_controller: expected outputs are queued
// with a cycle stamp and checked by an independent negedge monitor.
module tb_ssd_scan_controller;

    localparam int SD = 10;
    localparam int BC = 2;
    localparam int TF = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] input_bits;
    logic       dash;
    logic [3:0] dig_sel;
    logic       frame_tick;

    ssd_scan_controller #(
        .PAYLOAD_BITS  (8),
        .SCAN_DIV      (SD),
        .BLANK_CYCLES  (BC),
        .TIMEOUT_FRAMES(TF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .clear     (clear),
        .input_bits(input_bits),
        .dash      (dash),
        .dig_sel   (dig_sel),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] dig;
        logic [3:0] bits;
        logic       dsh;
        logic       tick;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   t0 = 0;
    int   compared = 0;
    int   mismatched = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            compared++;
            if (e.cyc != cyc || dig_sel !== e.dig || input_bits !== e.bits ||
                dash !== e.dsh || frame_tick !== e.tick) begin
                mismatched++;
                $display("FAIL %s p=%0d: got dig=%b bits=%h dash=%b tick=%b, want dig=%b bits=%h dash=%b tick=%b",
                         e.name, e.cyc - t0, dig_sel, input_bits, dash,
                         frame_tick, e.dig, e.bits, e.dsh, e.tick);
            end
        end
    end

    task automatic push(input int p, input logic [3:0] dg,
                        input logic [3:0] b, input logic d,
                        input logic tk, input string nm);
        exp_t e;
        e.cyc  = t0 + p;
        e.dig  = dg;
        e.bits = b;
        e.dsh  = d;
        e.tick = tk;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // One frame of expected outputs; bits holds {d3,d2,d1,d0} as latched.
    task automatic expect_frame(input int f, input logic [15:0] bits,
                                input logic [3:0] dsh,
                                input logic [3:0] mask, input string nm);
        logic [3:0] one;
        one = 4'b0001;
        for (int s = 0; s < 4; s++) begin
            if (mask[s]) begin
                for (int c = 0; c < SD; c++) begin
                    push(40 * f + SD * s + c,
                         (c < BC) ? 4'b0000 : (one << s),
                         bits[4*s +: 4], dsh[s],
                         (s == 3) && (c == SD - 1), nm);
                end
            end
        end
    endtask

    task automatic goto(input int p);
        while (cyc < t0 + p) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int p, input logic [7:0] d);
        goto(p);
        rx_data  = d;
        rx_valid = 1'b1;
        goto(p + 1);
        rx_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        t0 = cyc;

        expect_frame(0, 16'h0000, 4'b1111, 4'b1111, "idle");
        send(45, 8'hA5);
        expect_frame(2, 16'h00A5, 4'b1100, 4'b1111, "single");

        goto(125);
        rx_data  = 8'h12;
        rx_valid = 1'b1;
        goto(126);
        rx_data  = 8'h34;
        goto(127);
        rx_valid = 1'b0;
        expect_frame(4, 16'h1234, 4'b0000, 4'b1111, "b2b");

        expect_frame(5, 16'h3474, 4'b0000, 4'b1111, "midshow");
        expect_frame(6, 16'h3477, 4'b0000, 4'b1111, "midshow_next");
        send(205, 8'h77);

        expect_frame(9, 16'h3477, 4'b1111, 4'b1111, "timeout");

        send(405, 8'h9C);
        send(519, 8'h5E);
        expect_frame(14, 16'h9C5E, 4'b0000, 4'b0011, "rx_on_expiry");

        goto(605);
        clear    = 1'b1;
        rx_data  = 8'hFF;
        rx_valid = 1'b1;
        goto(606);
        clear    = 1'b0;
        rx_valid = 1'b0;
        expect_frame(16, 16'h9C5E, 4'b1111, 4'b1111, "clear_rx");

        goto(705);
        push(705, 4'b0000, 4'h0, 1'b1, 1'b0, "async_rst");
        rst = 1'b1;
        goto(708);
        rst = 1'b0;
        t0 = cyc;
        expect_frame(0, 16'h0000, 4'b1111, 4'b0011, "restart");

        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
